xorshift_inverter: RTL and testbench
====================================

XORSHIFT_INVERTER -- requirements
Module: xorshift_inverter

Interface
REQ-001 Parameters: none; data width fixed at 32 bits; shift triple fixed at 7 (right), 9 (left), 13 (right).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 gen_in  input  32  generated value, the output of the 7/9/13 xorshift, to be inverted.
REQ-006 in_valid  input  1  gen_in holds a valid value.
REQ-007 in_ready  output  1  block can accept an input.
REQ-008 seed_out  output  32  recovered seed.
REQ-009 out_valid  output  1  seed_out holds a valid result.
REQ-010 out_ready  input  1  downstream accepts seed_out.
REQ-011 check_ok  output  1  self-check result, qualified by out_valid (see Configuration).

Function
REQ-012 Function: seed_out SHALL be the unique x where fwd(x)==gen_in, with fwd(x) = c^(c>>13), c = b^(b<<9), b = x^(x>>7), all arithmetic on 32 bits and shifted-out bits discarded.
REQ-013 Method: one 32-bit working register t; undo each stage as a product of doubling steps t = t ^ (t op s).
REQ-014 States: IDLE, UNDO13, UNDO9, UNDO7, DONE; a step counter selects the shift within a state.
REQ-015 UNDO13 performs right-shift steps s=13, then 26 (2 cycles).
REQ-016 UNDO9 performs left-shift steps s=9, then 18 (2 cycles).
REQ-017 UNDO7 performs right-shift steps s=7, 14, then 28 (3 cycles).
REQ-018 IDLE: in_ready=1; on in_valid&&in_ready, load t<=gen_in and go to UNDO13 with step 0.
REQ-019 Compute states: in_ready=0, out_valid=0; exactly one step per clock; inputs ignored.
REQ-020 Latency: out_valid SHALL assert after the 7th rising edge following the accepting edge, with seed_out=t.
REQ-021 DONE: out_valid=1; seed_out and check_ok held stable until out_valid&&out_ready; then go to IDLE.
REQ-022 Throughput: one result per 9 cycles minimum; in_ready is never asserted in the same cycle as out_valid.
REQ-023 out_ready asserted outside DONE has no effect; in_valid asserted outside IDLE is not consumed.

Reset
REQ-024 While rst=1, the block SHALL be in IDLE with t=0, step counter=0, seed_out=0, out_valid=0, and check_ok=0.
REQ-025 in_ready SHALL equal 1 after reset is released, and SHALL be forced to 0 while rst=1.
REQ-026 Asserting rst mid-computation or in DONE SHALL discard the transaction; no out_valid pulse follows.

Configuration
REQ-027 Macro XORSHIFT_INV_CHECK_EN: when defined, the block captures gen_in at acceptance and computes fwd(seed_out) combinationally in DONE.
REQ-028 With XORSHIFT_INV_CHECK_EN defined, check_ok is 1 if fwd(seed_out) equals the captured value and 0 otherwise, registered on entry to DONE.
REQ-029 Without XORSHIFT_INV_CHECK_EN, no capture register or forward logic exists, and check_ok SHALL equal out_valid.

Verification
REQ-030 Reset: rst=1 mid-UNDO9 -> out_valid=0, seed_out=0, state IDLE; after release, in_ready=1 and no stale output appears.
REQ-031 Single transaction: gen_in=0x00000201 accepted at edge E -> out_valid=1 after edge E+7, seed_out=0x00000001, check_ok=1.
REQ-032 MSB vector: gen_in=0x81040800 -> seed_out=0x80000000; gen_in=0x00000000 -> seed_out=0x00000000.
REQ-033 Backpressure: hold out_ready=0 for 20 cycles in DONE -> seed_out stable, in_ready=0, and a pending in_valid is not consumed; out_ready=1 -> IDLE on the next edge.
REQ-034 Back-to-back: in_valid held high with gen_in 0x201, then 0x81040800, out_ready=1 -> outputs 0x1, then 0x80000000, in order, 9 cycles apart.
REQ-035 Random: 1000 random seeds, the bench applies fwd(seed) -> seed_out==seed for all; with XORSHIFT_INV_CHECK_EN, check_ok=1 for all.

Source files
------------

// File: rtl/xorshift_inverter.sv
// Recovers the seed of a 32-bit 7/9/13 xorshift step by undoing each stage with doubling steps.
// Optional self-check of the recovered seed is enabled with `define XORSHIFT_INV_CHECK_EN.
module xorshift_inverter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gen_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] seed_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        check_ok
);

  typedef enum logic [2:0] {IDLE, UNDO13, UNDO9, UNDO7, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] t, t_nxt;
  logic [1:0]  step, step_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      step  <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      step  <= step_nxt;
    end
  end

  // Inverse of (1 + S^k) is (1 + S^k)(1 + S^2k)(1 + S^4k)... truncated once the shift reaches 32.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    step_nxt  = step;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          t_nxt     = gen_in;
          state_nxt = UNDO13;
          step_nxt  = 2'd0;
        end
      end
      UNDO13: begin
        if (step == 2'd0) begin
          t_nxt    = t ^ (t >> 13);
          step_nxt = 2'd1;
        end else begin
          t_nxt     = t ^ (t >> 26);
          state_nxt = UNDO9;
          step_nxt  = 2'd0;
        end
      end
      UNDO9: begin
        if (step == 2'd0) begin
          t_nxt    = t ^ (t << 9);
          step_nxt = 2'd1;
        end else begin
          t_nxt     = t ^ (t << 18);
          state_nxt = UNDO7;
          step_nxt  = 2'd0;
        end
      end
      UNDO7: begin
        case (step)
          2'd0: begin
            t_nxt    = t ^ (t >> 7);
            step_nxt = 2'd1;
          end
          2'd1: begin
            t_nxt    = t ^ (t >> 14);
            step_nxt = 2'd2;
          end
          default: begin
            t_nxt     = t ^ (t >> 28);
            state_nxt = DONE;
            step_nxt  = 2'd0;
          end
        endcase
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  assign seed_out = t;

`ifdef XORSHIFT_INV_CHECK_EN
  logic [31:0] captured;
  logic        check_reg;

  function automatic logic [31:0] fwd(input logic [31:0] x);
    logic [31:0] b, c;
    b = x ^ (x >> 7);
    c = b ^ (b << 9);
    return c ^ (c >> 13);
  endfunction

  // The check result is registered on the final UNDO7 step so it is stable throughout DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      captured  <= '0;
      check_reg <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) captured <= gen_in;
      if (state == UNDO7 && step == 2'd2) check_reg <= (fwd(t_nxt) == captured);
    end
  end

  assign check_ok = out_valid & check_reg;
`else
  assign check_ok = out_valid;
`endif

endmodule

// File: tb/tb_xorshift_inverter.sv
// Scoreboard bench for xorshift_inverter: stimulus pushes expected seeds, a negedge monitor pops on handshake.
module tb_xorshift_inverter;

  logic        clk;
  logic        rst;
  logic [31:0] gen_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] seed_out;
  logic        out_valid;
  logic        out_ready;
  logic        check_ok;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [31:0] exp_q[$];
  int          pop_cycles[$];

  xorshift_inverter dut (
    .clk       (clk),
    .rst       (rst),
    .gen_in    (gen_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seed_out  (seed_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .check_ok  (check_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] fwd(input logic [31:0] x);
    logic [31:0] b, c;
    b = x ^ (x >> 7);
    c = b ^ (b << 9);
    return c ^ (c >> 13);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Offers one input, waits (bounded) for acceptance, then records the expected seed.
  task automatic applyStimulus(input logic [31:0] g, input logic [31:0] s);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    gen_in   = g;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back(s);
    else checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_valid", seed_out, 32'hFFFF_FFFF);
      end else begin
        checkOutput("seed_out", seed_out, exp_q.pop_front());
        checkOutput("check_ok", {31'd0, check_ok}, 32'd1);
        pop_cycles.push_back(cycle);
      end
    end
  end

  initial begin
    int n;
    int hits;
    logic [31:0] seed;

    rst       = 1'b1;
    gen_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_seed_out",  seed_out,           32'd0);
    checkOutput("rst_check_ok",  {31'd0, check_ok},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: out_valid first seen after the 7th edge following acceptance.
    @(posedge clk); #1;
    applyStimulus(32'h0000_0201, 32'h0000_0001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("latency_out_valid_%0d", k), {31'd0, out_valid}, (k == 7) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;

    applyStimulus(32'h8104_0800, 32'h8000_0000);
    applyStimulus(32'h0000_0000, 32'h0000_0000);
    repeat (12) @(posedge clk);
    #1;

    // Reset in the middle of UNDO9 discards the transaction.
    applyStimulus(32'h1234_5678, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_seed_out",  seed_out,           32'd0);
    checkOutput("midrst_in_ready",  {31'd0, in_ready},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
    hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    checkOutput("midrst_no_stale_output", hits, 32'd0);
    @(posedge clk); #1;

    // Backpressure: hold out_ready low in DONE with an input pending.
    out_ready = 1'b0;
    applyStimulus(32'h8104_0800, 32'h8000_0000);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_reached_done", {31'd0, out_valid}, 32'd1);
    gen_in   = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (seed_out !== 32'h8000_0000 || in_ready !== 1'b0 || out_valid !== 1'b1) hits++;
    end
    checkOutput("bp_hold_stable", hits, 32'd0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_back_to_idle", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_out_valid_low", {31'd0, out_valid}, 32'd0);

    // Back-to-back with in_valid held high.
    pop_cycles.delete();
    applyStimulus(32'h0000_0201, 32'h0000_0001);
    applyStimulus(32'h8104_0800, 32'h8000_0000);
    n = 0;
    while (pop_cycles.size() < 2 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (pop_cycles.size() >= 2)
      checkOutput("b2b_spacing", pop_cycles[1] - pop_cycles[0], 32'd9);
    else
      checkOutput("b2b_timeout", pop_cycles.size(), 32'd2);
    #1;

    // Random seeds run through the bench's forward model.
    for (int i = 0; i < 1000; i++) begin
      seed = $urandom;
      applyStimulus(fwd(seed), seed);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", exp_q.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
